vx_commit_arbiter: RTL
======================

# vx_commit_arbiter

Shares one per-issue-slot writeback/commit port among `NUM_REQS` execution-unit result streams, feeding the scoreboard release and register-file write path. Uses round-robin arbitration with packet locking: once a requester starts a multi-beat commit, it keeps the grant until its `eop` beat is accepted. This guarantees that a destination register is released exactly once, on the final beat. The output is registered through a one-entry elastic stage for timing isolation.

## Interface
- `NUM_REQS`, default 4: number of execution-unit commit streams (2..8).
- `DATAW`, default 64: commit payload width (wis, rd, PC, tmask, data, etc.), passed through unmodified.
- `CTR_W`, default 44: width of performance counters.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NUM_REQS`  per-requester beat valid.
- `req_data`  in  `NUM_REQS*DATAW`  per-requester payload, requester k at bits `[k*DATAW +: DATAW]`.
- `req_eop`  in  `NUM_REQS`  per-requester last-beat flag.
- `req_ready`  out  `NUM_REQS`  per-requester accept; at most one bit set per cycle.
- `out_valid`  out  1  registered commit beat valid.
- `out_data`  out  `DATAW`  registered payload.
- `out_eop`  out  1  registered last-beat flag (scoreboard clears `rd` on `out_valid && out_eop`).
- `out_idx`  out  `$clog2(NUM_REQS)`  source requester of the current output beat.
- `out_ready`  in  1  downstream accept.
- `perf_grants`  out  `NUM_REQS*CTR_W`  present only with `COMMIT_ARB_PERF_EN`.
- `perf_conflicts`  out  `CTR_W`  present only with `COMMIT_ARB_PERF_EN`.

## Operation

**Internal state**
- `rr_ptr` (`$clog2(NUM_REQS)`): highest-priority index.
- `locked` (1 bit), `lock_idx`.
- Output register: `out_valid`, `out_data`, `out_eop`, `out_idx`.

**Stage readiness**
- `stage_ready = ~out_valid | out_ready`.

**Grant selection**
- If `locked`: candidate = `lock_idx`, regardless of other valids.
- Otherwise: candidate = first index with `req_valid` set, searching `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQS`.
- `req_ready[candidate] = stage_ready && req_valid[candidate]`. All other `req_ready` bits are 0.
- Transfer (`fire`) = `|(req_valid & req_ready)`.

**On fire**
- Load the output register with the candidate's data, eop, and idx.
- If `req_eop` = 0: set `locked` = 1 and `lock_idx` = candidate. `rr_ptr` is unchanged.
- If `req_eop` = 1: set `locked` = 0 and `rr_ptr` = (candidate+1) mod `NUM_REQS`, wrapping from `NUM_REQS-1` to 0.

**Output register**
- If `out_ready && out_valid` with no new fire, `out_valid` drops to 0.
- Simultaneous drain and fire replaces the entry (full throughput, one beat per cycle).

**Lock behaviour**
- A locked requester that deasserts `req_valid` mid-packet stalls the port. The lock holds and no other requester is granted; this is intentional.
- Single-beat packets (`eop` = 1 on the first beat) never set `locked`.

## Timing
- Latency is 1 cycle from `req_valid && req_ready` to `out_valid`.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- `req_ready` depends combinationally on `out_ready`, `req_valid`, and state. `out_*` are purely registered.
- Reset values: `out_valid` = 0, `out_eop` = 0, `out_data` = 0, `out_idx` = 0, `rr_ptr` = 0, `locked` = 0, perf counters = 0.
- `req_ready` is 0 in the cycle `reset` is high.
- Reset mid-packet clears the lock and drops the buffered beat. Requesters are also reset, so no partial packet resumes.
- Backpressure: with `out_valid` = 1 and `out_ready` = 0, all `req_ready` = 0 and state holds.

## Configuration
- `COMMIT_ARB_PERF_EN` defined:
  - `perf_grants[k]` increments on each fire from requester k.
  - `perf_conflicts` increments each cycle where `stage_ready` = 1 and at least one valid requester is not granted. This includes requesters blocked by a lock.
  - Counters wrap modulo 2^`CTR_W` and are cleared by reset.
- `COMMIT_ARB_PERF_EN` undefined: perf ports and counters are absent. Arbitration behaviour is identical.

## Test plan
- **Round-robin, single-beat:** `NUM_REQS` = 4, all valid with eop = 1, `out_ready` = 1 → `out_idx` sequence 0, 1, 2, 3, 0, 1 on consecutive cycles, starting 1 cycle after the first fire.
- **Packet lock:** req1 sends 3 beats (eop on the 3rd) while req0 and req2 are valid → `out_idx` = 1, 1, 1, then 2; req0 is not granted until after req2.
- **Backpressure:** `out_ready` = 0 for 5 cycles with one beat buffered → `out_data` is stable, all `req_ready` = 0; on release, the next beat follows with no bubble.
- **Lock gap:** req3 sends a non-eop beat, then drops valid for 2 cycles while req0 is valid → req0 is not granted; req3's eop beat is the next output.
- **Reset mid-packet:** reset asserted after req2's first non-eop beat → the next cycle `out_valid` = 0 and `rr_ptr` = 0; a subsequent req0/req2 contention grants req0 first.
- **Perf (macro on):** 10 single-beat cycles with req0 and req1 both always valid → `perf_grants[0]` = 5, `perf_grants[1]` = 5, `perf_conflicts` = 10.

Source files
------------

// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter
// Shares one commit/writeback port among NUM_REQS execution-unit result
// streams. Round-robin arbitration with packet locking: a requester that
// starts a multi-beat commit keeps the grant until its eop beat is accepted,
// so the destination register is released exactly once, on the final beat.
// The output is a one-entry registered elastic stage.
// Optional feature macro: COMMIT_ARB_PERF_EN adds per-requester grant
// counters and a conflict counter (perf_grants / perf_conflicts ports).
module vx_commit_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int CTR_W    = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    input  logic [NUM_REQS-1:0]           req_eop,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          out_valid,
    output logic [DATAW-1:0]              out_data,
    output logic                          out_eop,
    output logic [$clog2(NUM_REQS)-1:0]   out_idx,
    input  logic                          out_ready
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [NUM_REQS*CTR_W-1:0]     perf_grants,
    output logic [CTR_W-1:0]              perf_conflicts
`endif
);

    localparam int IDX_W = $clog2(NUM_REQS);

    // (base + offset) modulo NUM_REQS, valid for any NUM_REQS (not only powers of two)
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
        int sum_v;
        sum_v = int'(base) + offset;
        if (sum_v >= NUM_REQS) begin
            sum_v = sum_v - NUM_REQS;
        end else begin
            sum_v = sum_v;
        end
        return IDX_W'(sum_v);
    endfunction

    logic [IDX_W-1:0]    rr_ptr_r;
    logic                locked_r;
    logic [IDX_W-1:0]    lock_idx_r;
    logic                out_valid_r;
    logic [DATAW-1:0]    out_data_r;
    logic                out_eop_r;
    logic [IDX_W-1:0]    out_idx_r;

    logic                stage_ready_s;
    logic [IDX_W-1:0]    cand_s;
    logic                found_s;
    logic [NUM_REQS-1:0] req_ready_s;
    logic                fire_s;
    logic [DATAW-1:0]    cand_data_s;
    logic                cand_eop_s;

    assign stage_ready_s = ~out_valid_r | out_ready;

    // Pick the candidate: the locked owner, else first valid requester from rr_ptr upward
    always_comb begin
        cand_s  = lock_idx_r;
        found_s = 1'b0;
        if (locked_r) begin
            cand_s = lock_idx_r;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!found_s && req_valid[rr_index(rr_ptr_r, i)]) begin
                    cand_s  = rr_index(rr_ptr_r, i);
                    found_s = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Grant only the candidate, and only when the stage can take a beat and we are out of reset
    always_comb begin
        req_ready_s = '0;
        if (!reset && stage_ready_s && req_valid[cand_s]) begin
            req_ready_s[cand_s] = 1'b1;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready   = req_ready_s;
    assign fire_s      = |(req_valid & req_ready_s);
    assign cand_data_s = req_data[int'(cand_s)*DATAW +: DATAW];
    assign cand_eop_s  = req_eop[cand_s];

    // Output stage, lock tracking and round-robin pointer update
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r    <= '0;
            locked_r    <= 1'b0;
            lock_idx_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_eop_r   <= 1'b0;
            out_idx_r   <= '0;
        end else begin
            if (fire_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= cand_data_s;
                out_eop_r   <= cand_eop_s;
                out_idx_r   <= cand_s;
                if (cand_eop_s) begin
                    locked_r <= 1'b0;
                    rr_ptr_r <= rr_index(cand_s, 1);
                end else begin
                    locked_r   <= 1'b1;
                    lock_idx_r <= cand_s;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_eop   = out_eop_r;
    assign out_idx   = out_idx_r;

`ifdef COMMIT_ARB_PERF_EN
    localparam logic [CTR_W-1:0] CTR_ONE = {{(CTR_W-1){1'b0}}, 1'b1};

    logic [CTR_W-1:0] grants_r [NUM_REQS];
    logic [CTR_W-1:0] conflicts_r;
    logic             conflict_s;

    // A conflict is a cycle where the stage could accept but some valid requester was left waiting
    assign conflict_s = stage_ready_s & (|(req_valid & ~req_ready_s));

    // Grant and conflict counters, wrapping naturally at 2^CTR_W
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_REQS; k++) begin
                grants_r[k] <= '0;
            end
            conflicts_r <= '0;
        end else begin
            for (int k = 0; k < NUM_REQS; k++) begin
                if (fire_s && (int'(cand_s) == k)) begin
                    grants_r[k] <= grants_r[k] + CTR_ONE;
                end else begin
                    grants_r[k] <= grants_r[k];
                end
            end
            if (conflict_s) begin
                conflicts_r <= conflicts_r + CTR_ONE;
            end else begin
                conflicts_r <= conflicts_r;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
        assign perf_grants[g*CTR_W +: CTR_W] = grants_r[g];
    end
    assign perf_conflicts = conflicts_r;
`endif

endmodule
